// File: rtl/control_merge_dataless_pkg.sv
// Shared handshake helpers for the dataless control merge.
package control_merge_dataless_pkg;

  localparam int unsigned DEFAULT_SIZE       = 2;
  localparam int unsigned DEFAULT_INDEX_TYPE = 2;

  // Number of bits needed to number n items (ceil(log2(n)), 0 for n <= 1).
  function automatic int unsigned clog2_width(input int unsigned n);
    for (int unsigned w = 0; w < 32; w++) begin
      if ((64'(1) << w) >= 64'(n)) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/control_merge_dataless_tehb.sv
// One-slot transparent buffer: passes data straight through when empty,
// parks it for one slot when the consumer stalls.
module control_merge_dataless_tehb #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] ins,
  input  logic         ins_valid,
  output logic         ins_ready,
  output logic [W-1:0] outs,
  output logic         outs_valid,
  input  logic         outs_ready
);

  logic         full;
  logic         full_next;
  logic [W-1:0] held;
  logic [W-1:0] held_next;

  // Transparent path when empty, parked value when full.
  assign outs_valid = full | ins_valid;
  assign outs       = full ? held : ins;
  assign ins_ready  = ~full;

  // Capture on a stalled arrival, release once the consumer takes it.
  always_comb begin
    full_next = full;
    held_next = held;
    if (!full && ins_valid && !outs_ready) begin
      full_next = 1'b1;
      held_next = ins;
    end else if (full && outs_ready) begin
      full_next = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      held <= '0;
    end else begin
      full <= full_next;
      held <= held_next;
    end
  end

endmodule

// File: rtl/control_merge_dataless.sv
// Dataless control merge: priority-picks one input token and forks it
// eagerly into a token output and an index output.
module control_merge_dataless
  import control_merge_dataless_pkg::*;
#(
  parameter int unsigned SIZE       = DEFAULT_SIZE,
  parameter int unsigned INDEX_TYPE = DEFAULT_INDEX_TYPE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE-1:0]       ins_valid,
  output logic [SIZE-1:0]       ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [INDEX_TYPE-1:0] index,
  output logic                  index_valid,
  input  logic                  index_ready
);

  if (SIZE < 1 || clog2_width(SIZE) > INDEX_TYPE) begin : g_bad_size
    $error("control_merge_dataless: SIZE must be >= 1 and fit in INDEX_TYPE bits");
  end

  logic                  merge_valid;
  logic [INDEX_TYPE-1:0] winner;
  logic                  buf_valid;
  logic                  buf_ready;
  logic [INDEX_TYPE-1:0] buf_index;
  logic [1:0]            sent;
  logic [1:0]            sent_next;
  logic                  done0;
  logic                  done1;
  logic                  fork_ready;

  // Reset gates the merge so nothing is offered or accepted while rst is low.
  assign merge_valid = rst & (|ins_valid);

  // Lowest-numbered valid input wins.
  always_comb begin
    winner = '0;
    for (int i = int'(SIZE) - 1; i >= 0; i--) begin
      if (rst && ins_valid[i]) winner = INDEX_TYPE'(i);
    end
  end

  // Only the winner sees ready, and only while the buffer can take it.
  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      ins_ready[i] = merge_valid & buf_ready & (winner == INDEX_TYPE'(i));
    end
  end

  control_merge_dataless_tehb #(
    .W (INDEX_TYPE)
  ) u_tehb (
    .clk        (clk),
    .rst        (rst),
    .ins        (winner),
    .ins_valid  (merge_valid),
    .ins_ready  (buf_ready),
    .outs       (buf_index),
    .outs_valid (buf_valid),
    .outs_ready (fork_ready)
  );

  // Eager fork: each branch drops its valid once it has taken the token.
  assign outs_valid  = buf_valid & ~sent[0];
  assign index_valid = buf_valid & ~sent[1];
  assign index       = buf_index;
  assign done0       = sent[0] | outs_ready;
  assign done1       = sent[1] | index_ready;
  assign fork_ready  = done0 & done1;

  // Remember accepted branches until both are done.
  always_comb begin
    sent_next = '0;
    if (buf_valid && !fork_ready) begin
      sent_next = sent | {index_valid & index_ready, outs_valid & outs_ready};
    end
  end

  // Fork state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sent <= '0;
    else      sent <= sent_next;
  end

endmodule

// File: tb/tb_control_merge_dataless.sv
// Bench for control_merge_dataless: directed scenarios plus a random
// handshake run, with a queue-based scoreboard on both output branches.
module tb_control_merge_dataless;

  localparam int unsigned SIZE = 4;
  localparam int unsigned IW   = 2;

  logic            clk;
  logic            rst;
  logic [SIZE-1:0] ins_valid;
  logic [SIZE-1:0] ins_ready;
  logic            outs_valid;
  logic            outs_ready;
  logic [IW-1:0]   index;
  logic            index_valid;
  logic            index_ready;

  int n_checks = 0;
  int n_fail   = 0;

  int            q_idx[$];
  int            q_outs[$];
  logic [SIZE-1:0] acc_mask;
  logic          prev_hold;
  logic [IW-1:0] prev_index;

  control_merge_dataless #(
    .SIZE       (SIZE),
    .INDEX_TYPE (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .outs_valid  (outs_valid),
    .outs_ready  (outs_ready),
    .index       (index),
    .index_valid (index_valid),
    .index_ready (index_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest(input logic [SIZE-1:0] v);
    for (int i = 0; i < int'(SIZE); i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [SIZE-1:0] lowest_onehot(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = int'(SIZE) - 1; i >= 0; i--) if (v[i]) r = SIZE'(1) << i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the four visible outputs; index only matters while index_valid.
  task automatic see(input string t, input logic ov, input logic iv,
                     input logic [IW-1:0] ix, input logic [SIZE-1:0] ir);
    chk({t, ".outs_valid"}, 32'(outs_valid), 32'(ov));
    chk({t, ".index_valid"}, 32'(index_valid), 32'(iv));
    chk({t, ".ins_ready"}, 32'(ins_ready), 32'(ir));
    if (iv) chk({t, ".index"}, 32'(index), 32'(ix));
  endtask

  // Drive one cycle of stimulus just after the edge, settle to the negedge.
  task automatic drive(input logic [SIZE-1:0] v, input logic o, input logic i);
    @(posedge clk);
    #1;
    ins_valid   = v;
    outs_ready  = o;
    index_ready = i;
    @(negedge clk);
  endtask

  // Scoreboard: push on input acceptance, pop on each branch handshake.
  always @(negedge clk) begin
    if (!rst) begin
      q_idx.delete();
      q_outs.delete();
      prev_hold = 1'b0;
      acc_mask  = '0;
    end else begin
      acc_mask = ins_valid & ins_ready;
      if (ins_ready != '0) begin
        chk("ins_ready_onehot", 32'(ins_ready), 32'(lowest_onehot(ins_valid)));
        q_idx.push_back(lowest(ins_valid));
        q_outs.push_back(lowest(ins_valid));
      end
      if (prev_hold) begin
        chk("index_valid_held", 32'(index_valid), 32'(1));
        chk("index_stable", 32'(index), 32'(prev_index));
      end
      if (outs_valid && outs_ready) begin
        chk("outs_nonempty", 32'(q_outs.size() != 0), 32'(1));
        if (q_outs.size() != 0) void'(q_outs.pop_front());
      end
      if (index_valid && index_ready) begin
        chk("index_nonempty", 32'(q_idx.size() != 0), 32'(1));
        if (q_idx.size() != 0) begin
          int e;
          e = q_idx.pop_front();
          chk("index_order", 32'(index), 32'(e));
        end
      end
      prev_hold  = index_valid & ~index_ready;
      prev_index = index;
    end
  end

  initial begin
    rst         = 1'b0;
    ins_valid   = '1;
    outs_ready  = 1'b1;
    index_ready = 1'b1;

    // Reset forces every handshake output low even with inputs valid.
    #3;
    see("reset", 1'b0, 1'b0, '0, '0);
    chk("reset.index", 32'(index), 32'(0));
    @(posedge clk);
    #1;
    rst       = 1'b1;
    ins_valid = '0;

    // Single input, zero latency.
    drive(4'b0100, 1'b1, 1'b1);
    see("single.c0", 1'b1, 1'b1, 2'd2, 4'b0100);
    drive(4'b0000, 1'b1, 1'b1);
    see("single.c1", 1'b0, 1'b0, '0, 4'b0000);

    // Contention: lower index wins, the loser waits.
    drive(4'b1010, 1'b1, 1'b1);
    see("contend.c0", 1'b1, 1'b1, 2'd1, 4'b0010);
    drive(4'b1000, 1'b1, 1'b1);
    see("contend.c1", 1'b1, 1'b1, 2'd3, 4'b1000);
    drive(4'b0000, 1'b1, 1'b1);
    see("contend.c2", 1'b0, 1'b0, '0, 4'b0000);

    // Split acceptance: outs takes it at once, index stalls two cycles.
    drive(4'b0001, 1'b1, 1'b0);
    see("split.c0", 1'b1, 1'b1, 2'd0, 4'b0001);
    drive(4'b0000, 1'b1, 1'b0);
    see("split.c1", 1'b0, 1'b1, 2'd0, 4'b0000);
    drive(4'b0000, 1'b1, 1'b0);
    see("split.c2", 1'b0, 1'b1, 2'd0, 4'b0000);
    drive(4'b0000, 1'b1, 1'b1);
    see("split.c3", 1'b0, 1'b1, 2'd0, 4'b0000);
    drive(4'b0000, 1'b1, 1'b1);
    see("split.c4", 1'b0, 1'b0, '0, 4'b0000);

    // Full buffer: held index has priority, new arrival blocked.
    drive(4'b0100, 1'b0, 1'b0);
    see("full.c0", 1'b1, 1'b1, 2'd2, 4'b0100);
    drive(4'b0001, 1'b0, 1'b0);
    see("full.c1", 1'b1, 1'b1, 2'd2, 4'b0000);
    drive(4'b0001, 1'b1, 1'b1);
    see("full.c2", 1'b1, 1'b1, 2'd2, 4'b0000);
    drive(4'b0001, 1'b1, 1'b1);
    see("full.c3", 1'b1, 1'b1, 2'd0, 4'b0001);
    drive(4'b0000, 1'b1, 1'b1);
    see("full.c4", 1'b0, 1'b0, '0, 4'b0000);

    // Reset while full with only the token branch done.
    drive(4'b1000, 1'b1, 1'b0);
    see("rstmid.c0", 1'b1, 1'b1, 2'd3, 4'b1000);
    drive(4'b0000, 1'b1, 1'b0);
    see("rstmid.c1", 1'b0, 1'b1, 2'd3, 4'b0000);
    #1;
    rst       = 1'b0;
    ins_valid = 4'b0010;
    #1;
    see("rstmid.asserted", 1'b0, 1'b0, '0, 4'b0000);
    chk("rstmid.index", 32'(index), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    ins_valid   = '0;
    outs_ready  = 1'b1;
    index_ready = 1'b1;
    @(negedge clk);
    see("rstmid.after0", 1'b0, 1'b0, '0, 4'b0000);
    drive(4'b0000, 1'b1, 1'b1);
    see("rstmid.after1", 1'b0, 1'b0, '0, 4'b0000);

    // Random valids and readies; inputs hold valid until accepted.
    for (int c = 0; c < 10000; c++) begin
      logic [SIZE-1:0] v;
      @(posedge clk);
      #1;
      v = ins_valid & ~acc_mask;
      for (int i = 0; i < int'(SIZE); i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) v[i] = 1'b1;
      end
      ins_valid   = v;
      outs_ready  = ($urandom_range(0, 3) != 0);
      index_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain: stop offering tokens, let both branches empty out.
    @(posedge clk);
    #1;
    ins_valid   = ins_valid & ~acc_mask;
    outs_ready  = 1'b1;
    index_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      ins_valid = ins_valid & ~acc_mask;
    end
    @(negedge clk);
    chk("drain.inputs", 32'(ins_valid), 32'(0));
    chk("drain.idx_queue", 32'(q_idx.size()), 32'(0));
    chk("drain.outs_queue", 32'(q_outs.size()), 32'(0));
    see("drain.idle", 1'b0, 1'b0, '0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
